ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_if.sv | 24 ++
 rtl/ifetch_queue.sv | 132 +++++++++++++
 tb/tb_ifetch_queue.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-queue bundle: redirect, instruction-memory request/ack, and the consumer-side instruction stream.
// master = fetch queue, slave = memory/consumer environment.
interface ifetch_queue_if;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one outstanding memory request, DEPTH-entry FIFO of {word, pc}, redirect flush.
// Optional macro IFQ_BYPASS_EN forwards an acked word straight to the consumer when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_queue_if.master ifq
);
  localparam int            CW     = $clog2(DEPTH);
  localparam logic [CW:0]   L_FULL = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW:0]     r_count, w_count_nxt;
  logic [CW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [31:0]     r_mem_data [DEPTH];
  logic [7:0]      r_mem_pc   [DEPTH];
  logic [7:0]      r_fetch_pc, w_fetch_pc_nxt;
  logic [7:0]      r_imem_addr, w_imem_addr_nxt, w_addr_inc;
  logic            r_imem_req, w_imem_req_nxt;
  logic            w_head_valid, w_push, w_pop, w_byp_take;

  assign w_head_valid = (r_count != '0);
  assign w_addr_inc   = r_imem_addr + 8'd4;

`ifdef IFQ_BYPASS_EN
  logic w_byp;
  // Empty queue and a live ack: present the memory word directly to the consumer.
  assign w_byp          = !w_head_valid && (r_state == REQ) && ifq.imem_ack && !ifq.redirect;
  assign w_byp_take     = w_byp && ifq.inst_ready;
  assign ifq.inst_valid = w_head_valid || w_byp;
  assign ifq.inst_data  = w_byp ? ifq.imem_rdata : r_mem_data[r_rd_ptr];
  assign ifq.inst_pc    = w_byp ? r_imem_addr    : r_mem_pc[r_rd_ptr];
`else
  assign w_byp_take     = 1'b0;
  assign ifq.inst_valid = w_head_valid;
  assign ifq.inst_data  = r_mem_data[r_rd_ptr];
  assign ifq.inst_pc    = r_mem_pc[r_rd_ptr];
`endif

  assign w_pop  = w_head_valid && ifq.inst_ready && !ifq.redirect;
  assign w_push = (r_state == REQ) && ifq.imem_ack && !ifq.redirect && !w_byp_take;

  assign ifq.imem_req  = r_imem_req;
  assign ifq.imem_addr = r_imem_addr;

  always_comb begin
    w_state_nxt     = r_state;
    w_imem_req_nxt  = r_imem_req;
    w_imem_addr_nxt = r_imem_addr;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_count_nxt     = r_count + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
    if (ifq.redirect) begin
      w_count_nxt    = '0;
      w_fetch_pc_nxt = ifq.redirect_pc;
    end
    case (r_state)
      IDLE: begin
        if (!ifq.redirect && (r_count < L_FULL)) begin
          w_state_nxt     = REQ;
          w_imem_req_nxt  = 1'b1;
          w_imem_addr_nxt = r_fetch_pc;
        end
      end
      REQ: begin
        if (ifq.redirect) begin
          // Old request must still complete on the bus; DROP swallows its data.
          if (ifq.imem_ack) begin
            w_state_nxt    = IDLE;
            w_imem_req_nxt = 1'b0;
          end else begin
            w_state_nxt    = DROP;
          end
        end else if (ifq.imem_ack) begin
          w_fetch_pc_nxt = w_addr_inc;
          if (w_count_nxt < L_FULL) begin
            w_imem_addr_nxt = w_addr_inc;
          end else begin
            w_state_nxt    = IDLE;
            w_imem_req_nxt = 1'b0;
          end
        end
      end
      DROP: begin
        if (ifq.imem_ack) begin
          w_state_nxt    = IDLE;
          w_imem_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_imem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_fetch_pc  <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= 8'h00;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_imem_req  <= w_imem_req_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      if (ifq.redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= ifq.imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_imem_addr;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue; memory returns {24'hC0FFEE, addr} unless a fixed word is selected.
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic use_fixed = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  ifetch_queue_if ifq();
  assign ifq.imem_rdata = use_fixed ? 32'hDEADBEEF : {24'hC0FFEE, ifq.imem_addr};

  ifetch_queue #(.DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifq   (ifq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    ifq.redirect = 1'b0;
    ifq.redirect_pc = 8'h00;
    ifq.imem_ack = 1'b0;
    ifq.inst_ready = 1'b0;
    use_fixed = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ifq.redirect = 1'b0;
    ifq.redirect_pc = 8'h00;
    ifq.imem_ack = 1'b0;
    ifq.inst_ready = 1'b0;
    #1;
    total++;
    if (ifq.imem_req !== 1'b0 || ifq.imem_addr !== 8'h00 || ifq.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals req=%b addr=%h valid=%b exp 0/00/0", ifq.imem_req, ifq.imem_addr, ifq.inst_valid);
    end
    tick;
    rst_n = 1'b1;
    #1;
    total++;
    if (ifq.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_cycle req=%b exp 0", ifq.imem_req);
    end
    tick;
    total++;
    if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_second_cycle req=%b addr=%h exp 1/00", ifq.imem_req, ifq.imem_addr);
    end
  endtask

  task automatic test_stream;
    logic [7:0] exp_pc;
    do_reset;
    ifq.imem_ack = 1'b1;
    ifq.inst_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      total++;
      if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'(4*c)) begin
        bad++;
        $display("FAIL stream_addr c=%0d req=%b addr=%h exp 1/%h", c, ifq.imem_req, ifq.imem_addr, 8'(4*c));
      end
      total++;
      if (c >= LAT) begin
        exp_pc = 8'(4*(c-LAT));
        if (ifq.inst_valid !== 1'b1 || ifq.inst_pc !== exp_pc || ifq.inst_data !== {24'hC0FFEE, exp_pc}) begin
          bad++;
          $display("FAIL stream_inst c=%0d valid=%b pc=%h data=%h exp pc %h", c, ifq.inst_valid, ifq.inst_pc, ifq.inst_data, exp_pc);
        end
      end else if (ifq.inst_valid !== 1'b0) begin
        bad++;
        $display("FAIL stream_empty c=%0d valid=%b exp 0", c, ifq.inst_valid);
      end
    end
    ifq.imem_ack = 1'b0;
  endtask

  task automatic test_full;
    do_reset;
    ifq.imem_ack = 1'b1;
    ifq.inst_ready = 1'b0;
    repeat (5) tick;
    total++;
    if (ifq.imem_req !== 1'b0 || ifq.inst_valid !== 1'b1 || ifq.inst_pc !== 8'h00) begin
      bad++;
      $display("FAIL full_stop req=%b valid=%b pc=%h exp 0/1/00", ifq.imem_req, ifq.inst_valid, ifq.inst_pc);
    end
    tick;
    total++;
    if (ifq.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL full_hold req=%b exp 0", ifq.imem_req);
    end
    ifq.inst_ready = 1'b1;
    tick;
    ifq.inst_ready = 1'b0;
    tick;
    total++;
    if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'h10) begin
      bad++;
      $display("FAIL full_refill req=%b addr=%h exp 1/10", ifq.imem_req, ifq.imem_addr);
    end
    tick;
    total++;
    if (ifq.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL full_single req=%b exp 0", ifq.imem_req);
    end
    ifq.imem_ack = 1'b0;
    ifq.inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (ifq.inst_valid !== 1'b1 || ifq.inst_pc !== 8'(4 + 4*k)) begin
        bad++;
        $display("FAIL full_drain k=%0d valid=%b pc=%h exp %h", k, ifq.inst_valid, ifq.inst_pc, 8'(4 + 4*k));
      end
      tick;
    end
    total++;
    if (ifq.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_empty valid=%b exp 0", ifq.inst_valid);
    end
    ifq.inst_ready = 1'b0;
  endtask

  task automatic test_redirect;
    do_reset;
    tick;
    ifq.redirect = 1'b1;
    ifq.redirect_pc = 8'h40;
    tick;
    ifq.redirect = 1'b0;
    total++;
    if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'h00) begin
      bad++;
      $display("FAIL redir_hold req=%b addr=%h exp 1/00", ifq.imem_req, ifq.imem_addr);
    end
    tick;
    tick;
    ifq.imem_ack = 1'b1;
    #1;
    total++;
    if (ifq.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_drop_ack valid=%b exp 0", ifq.inst_valid);
    end
    tick;
    ifq.imem_ack = 1'b0;
    #1;
    total++;
    if (ifq.imem_req !== 1'b0 || ifq.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_dropped req=%b valid=%b exp 0/0", ifq.imem_req, ifq.inst_valid);
    end
    tick;
    total++;
    if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'h40 || ifq.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_restart req=%b addr=%h valid=%b exp 1/40/0", ifq.imem_req, ifq.imem_addr, ifq.inst_valid);
    end
    ifq.imem_ack = 1'b1;
    tick;
    ifq.imem_ack = 1'b0;
    #1;
    total++;
    if (ifq.inst_valid !== 1'b1 || ifq.inst_pc !== 8'h40 || ifq.inst_data !== 32'hC0FFEE40) begin
      bad++;
      $display("FAIL redir_first valid=%b pc=%h data=%h exp 1/40/C0FFEE40", ifq.inst_valid, ifq.inst_pc, ifq.inst_data);
    end
  endtask

  task automatic test_flush;
    do_reset;
    ifq.imem_ack = 1'b1;
    repeat (5) tick;
    ifq.redirect = 1'b1;
    ifq.redirect_pc = 8'h80;
    tick;
    ifq.redirect = 1'b0;
    total++;
    if (ifq.inst_valid !== 1'b0 || ifq.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty valid=%b req=%b exp 0/0", ifq.inst_valid, ifq.imem_req);
    end
    tick;
    total++;
    if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'h80) begin
      bad++;
      $display("FAIL flush_restart req=%b addr=%h exp 1/80", ifq.imem_req, ifq.imem_addr);
    end
    ifq.imem_ack = 1'b0;
  endtask

  task automatic test_wrap;
    logic [7:0] exp_pc;
    do_reset;
    ifq.redirect = 1'b1;
    ifq.redirect_pc = 8'hF8;
    tick;
    ifq.redirect = 1'b0;
    ifq.imem_ack = 1'b1;
    ifq.inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      exp_pc = 8'(8'hF8 + 4*k);
      total++;
      if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== exp_pc) begin
        bad++;
        $display("FAIL wrap_addr k=%0d addr=%h exp %h", k, ifq.imem_addr, exp_pc);
      end
      if (k >= LAT) begin
        exp_pc = 8'(8'hF8 + 4*(k-LAT));
        total++;
        if (ifq.inst_valid !== 1'b1 || ifq.inst_pc !== exp_pc) begin
          bad++;
          $display("FAIL wrap_inst k=%0d valid=%b pc=%h exp %h", k, ifq.inst_valid, ifq.inst_pc, exp_pc);
        end
      end
    end
    ifq.imem_ack = 1'b0;
    ifq.inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    ifq.imem_ack = 1'b1;
    tick;
    tick;
    tick;
    ifq.imem_ack = 1'b0;
    #1;
    total++;
    if (ifq.inst_valid !== 1'b1 || ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'h08) begin
      bad++;
      $display("FAIL rmid_pre valid=%b req=%b addr=%h exp 1/1/08", ifq.inst_valid, ifq.imem_req, ifq.imem_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ifq.imem_req !== 1'b0 || ifq.imem_addr !== 8'h00 || ifq.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async req=%b addr=%h valid=%b exp 0/00/0", ifq.imem_req, ifq.imem_addr, ifq.inst_valid);
    end
    ifq.imem_ack = 1'b1;
    tick;
    rst_n = 1'b1;
    #1;
    total++;
    if (ifq.inst_valid !== 1'b0 || ifq.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rmid_late_ack valid=%b req=%b exp 0/0", ifq.inst_valid, ifq.imem_req);
    end
    ifq.imem_ack = 1'b0;
    tick;
    total++;
    if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'h00 || ifq.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_restart req=%b addr=%h valid=%b exp 1/00/0", ifq.imem_req, ifq.imem_addr, ifq.inst_valid);
    end
  endtask

  task automatic test_bypass;
    do_reset;
    ifq.inst_ready = 1'b1;
    use_fixed = 1'b1;
    tick;
    ifq.imem_ack = 1'b1;
    #1;
    total++;
    if (ifq.inst_valid !== (LAT == 0) || (LAT == 0 && ifq.inst_data !== 32'hDEADBEEF)) begin
      bad++;
      $display("FAIL byp_ack_cycle valid=%b data=%h exp valid %0d", ifq.inst_valid, ifq.inst_data, (LAT == 0));
    end
    tick;
    ifq.imem_ack = 1'b0;
    #1;
    total++;
    if (ifq.inst_valid !== (LAT == 1) || (LAT == 1 && (ifq.inst_data !== 32'hDEADBEEF || ifq.inst_pc !== 8'h00))) begin
      bad++;
      $display("FAIL byp_next_cycle valid=%b data=%h pc=%h exp valid %0d", ifq.inst_valid, ifq.inst_data, ifq.inst_pc, (LAT == 1));
    end
    total++;
    if (ifq.imem_req !== 1'b1 || ifq.imem_addr !== 8'h04) begin
      bad++;
      $display("FAIL byp_next_req req=%b addr=%h exp 1/04", ifq.imem_req, ifq.imem_addr);
    end
    tick;
    total++;
    if (ifq.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL byp_consumed valid=%b exp 0", ifq.inst_valid);
    end
    use_fixed = 1'b0;
  endtask

  initial begin
    ifq.redirect = 1'b0;
    ifq.redirect_pc = 8'h00;
    ifq.imem_ack = 1'b0;
    ifq.inst_ready = 1'b0;
    test_reset;
    test_stream;
    test_full;
    test_redirect;
    test_flush;
    test_wrap;
    test_reset_mid;
    test_bypass;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
